// File: rtl/box_pkg.sv
// Shared constants and helpers for the one-to-eight box distributor.
package box_pkg;
  localparam int NUM_SLOTS = 8;
  localparam int PTR_W     = 3;
  localparam int CNT_W     = 4;

  localparam logic MODE_RR   = 1'b0;
  localparam logic MODE_ADDR = 1'b1;

  function automatic logic [CNT_W-1:0] f_popcnt(input logic [NUM_SLOTS-1:0] v);
    logic [CNT_W-1:0] n;
    n = '0;
    for (int i = 0; i < NUM_SLOTS; i++) n = n + CNT_W'(v[i]);
    return n;
  endfunction
endpackage

// File: rtl/box_if.sv
// Producer/consumer bundle of the box distributor; master = environment, slave = distributor.
interface box_if #(parameter int WIREWIDTH = 1);
  import box_pkg::*;

  logic                 s;
  logic                 in_valid;
  logic                 in_ready;
  logic [WIREWIDTH:0]   d;
  logic [PTR_W-1:0]     addr;
  logic [WIREWIDTH:0]   o0, o1, o2, o3, o4, o5, o6, o7;
  logic [NUM_SLOTS-1:0] o_valid;
  logic [NUM_SLOTS-1:0] o_ack;
  logic [PTR_W-1:0]     ptr;
  logic [CNT_W-1:0]     fill_count;

  modport master (
    output s, in_valid, d, addr, o_ack,
    input  in_ready, o0, o1, o2, o3, o4, o5, o6, o7, o_valid, ptr, fill_count
  );

  modport slave (
    input  s, in_valid, d, addr, o_ack,
    output in_ready, o0, o1, o2, o3, o4, o5, o6, o7, o_valid, ptr, fill_count
  );
endinterface

// File: rtl/box_slot.sv
// One output slot: data register plus valid flag; a load in the same cycle as an ack keeps the slot full.
module box_slot #(
  parameter int WIREWIDTH = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_load,
  input  logic               i_ack,
  input  logic [WIREWIDTH:0] i_din,
  output logic [WIREWIDTH:0] o_dout,
  output logic               o_valid
);
  logic [WIREWIDTH:0] r_data;
  logic               r_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_data  <= '0;
      r_valid <= 1'b0;
    end else begin
      if (i_load) r_data <= i_din;
      if (i_load)       r_valid <= 1'b1;
      else if (i_ack)   r_valid <= 1'b0;
    end
  end

  assign o_dout  = r_data;
  assign o_valid = r_valid;
endmodule

// File: rtl/box_distributor.sv
// Steers one handshaked input stream into eight registered slots, by round-robin pointer or explicit address.
module box_distributor
  import box_pkg::*;
#(
  parameter int WIREWIDTH = 1
) (
  input  logic clk,
  input  logic rst,
  box_if.slave bif
);
  logic [PTR_W-1:0]                   r_ptr;
  logic [CNT_W-1:0]                   r_cnt;
  logic [CNT_W-1:0]                   w_cnt_nxt;
  logic [PTR_W-1:0]                   w_tgt;
  logic                               w_ready;
  logic                               w_accept;
  logic [NUM_SLOTS-1:0]               w_load;
  logic [NUM_SLOTS-1:0]               w_valid;
  logic [NUM_SLOTS-1:0]               w_drain;
  logic [NUM_SLOTS-1:0][WIREWIDTH:0]  w_dout;

  assign w_tgt    = (bif.s == MODE_ADDR) ? bif.addr : r_ptr;
  // Ready never looks at in_valid, so the producer can't form a loop through it.
  assign w_ready  = ~w_valid[w_tgt] | bif.o_ack[w_tgt];
  assign w_accept = bif.in_valid & w_ready;
  assign w_drain  = bif.o_ack & w_valid;

  always_comb begin
    w_load = '0;
    for (int i = 0; i < NUM_SLOTS; i++)
      w_load[i] = w_accept && (w_tgt == PTR_W'(i));
  end

  genvar g;
  generate
    for (g = 0; g < NUM_SLOTS; g++) begin : g_slot
      box_slot #(.WIREWIDTH(WIREWIDTH)) u_slot (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_load[g]),
        .i_ack   (w_drain[g]),
        .i_din   (bif.d),
        .o_dout  (w_dout[g]),
        .o_valid (w_valid[g])
      );
    end
  endgenerate

  // Per-slot delta: fill of an empty slot +1, drain without refill -1, refill of a draining slot 0.
  always_comb begin
    w_cnt_nxt = r_cnt;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (w_load[i] && !w_valid[i])       w_cnt_nxt = w_cnt_nxt + CNT_W'(1);
      else if (w_drain[i] && !w_load[i])  w_cnt_nxt = w_cnt_nxt - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
      r_cnt <= '0;
    end else begin
      if (w_accept && bif.s == MODE_RR) r_ptr <= r_ptr + PTR_W'(1);
      r_cnt <= w_cnt_nxt;
    end
  end

  assign bif.in_ready   = w_ready;
  assign bif.o_valid    = w_valid;
  assign bif.ptr        = r_ptr;
  assign bif.fill_count = r_cnt;
  assign bif.o0 = w_dout[0];
  assign bif.o1 = w_dout[1];
  assign bif.o2 = w_dout[2];
  assign bif.o3 = w_dout[3];
  assign bif.o4 = w_dout[4];
  assign bif.o5 = w_dout[5];
  assign bif.o6 = w_dout[6];
  assign bif.o7 = w_dout[7];
endmodule

// File: tb/tb_box_distributor.sv
// Directed scenarios plus randomized traffic against a slot-array model of the distributor.
module tb_box_distributor;
  localparam int W = 3;

  logic clk = 1'b0;
  logic rst;
  int   n_vec = 0;
  int   n_err = 0;

  box_if #(.WIREWIDTH(W)) bif ();
  box_distributor #(.WIREWIDTH(W)) dut (.clk(clk), .rst(rst), .bif(bif));

  always #5 clk = ~clk;

  logic [W:0] w_o [8];
  assign w_o[0] = bif.o0; assign w_o[1] = bif.o1;
  assign w_o[2] = bif.o2; assign w_o[3] = bif.o3;
  assign w_o[4] = bif.o4; assign w_o[5] = bif.o5;
  assign w_o[6] = bif.o6; assign w_o[7] = bif.o7;

  // Reference: eight slots as plain arrays; count recomputed from scratch.
  logic [W:0] m_data [8];
  logic [7:0] m_valid;
  logic [2:0] m_ptr;
  bit         m_started = 0;

  function automatic int m_count();
    int n = 0;
    for (int i = 0; i < 8; i++) n += int'(m_valid[i]);
    return n;
  endfunction

  function automatic logic m_ready();
    int t = bif.s ? int'(bif.addr) : int'(m_ptr);
    return !m_valid[t] || bif.o_ack[t];
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) m_data[i] = '0;
      m_valid = '0; m_ptr = '0; m_started = 1;
    end else if (m_started) begin
      int  t;
      bit  acc;
      t   = bif.s ? int'(bif.addr) : int'(m_ptr);
      acc = bif.in_valid && m_ready();
      m_valid = m_valid & ~bif.o_ack;
      if (acc) begin
        m_data[t] = bif.d;
        m_valid[t] = 1'b1;
        if (!bif.s) m_ptr = 3'((int'(m_ptr) + 1) % 8);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h want %0h", nm, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (m_started) begin
      chk("o_valid", 32'(bif.o_valid), 32'(m_valid));
      chk("ptr", 32'(bif.ptr), 32'(m_ptr));
      chk("fill_count", 32'(bif.fill_count), 32'(m_count()));
      chk("in_ready", 32'(bif.in_ready), 32'(m_ready()));
      for (int i = 0; i < 8; i++) chk($sformatf("o%0d", i), 32'(w_o[i]), 32'(m_data[i]));
    end
  end

  task automatic drv(input logic iv, input logic s, input logic [2:0] a,
                     input logic [W:0] d, input logic [7:0] ack);
    bif.in_valid = iv; bif.s = s; bif.addr = a; bif.d = d; bif.o_ack = ack;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1;
    drv(0, 0, 0, 0, 0);
    repeat (2) tick();
    rst = 1'b0;
    chk("rst o_valid", 32'(bif.o_valid), 32'h0);
    chk("rst in_ready", 32'(bif.in_ready), 32'h1);
    chk("rst o3", 32'(bif.o3), 32'h0);

    // Round-robin fill of all eight slots
    for (int i = 0; i < 8; i++) begin
      drv(1, 0, 0, 4'(i), 0);
      tick();
    end
    chk("rr o_valid", 32'(bif.o_valid), 32'hFF);
    chk("rr fill", 32'(bif.fill_count), 32'd8);
    chk("rr ptr", 32'(bif.ptr), 32'd0);
    chk("rr in_ready", 32'(bif.in_ready), 32'd0);
    chk("rr o6", 32'(bif.o6), 32'd6);

    // Full stall, then release via ack on slot 0
    drv(1, 0, 0, 4'd9, 0);
    tick();
    chk("stall ptr", 32'(bif.ptr), 32'd0);
    bif.o_ack = 8'h01; #1;
    chk("release ready", 32'(bif.in_ready), 32'd1);
    tick();
    chk("release ptr", 32'(bif.ptr), 32'd1);
    chk("release fill", 32'(bif.fill_count), 32'd8);
    chk("release o0", 32'(bif.o0), 32'd9);

    // Drain everything, then addressed writes
    drv(0, 0, 0, 0, 8'hFF); tick();
    chk("drain fill", 32'(bif.fill_count), 32'd0);
    drv(1, 1, 5, 4'hA, 0); tick();
    chk("addr o5", 32'(bif.o5), 32'hA);
    chk("addr o_valid", 32'(bif.o_valid), 32'h20);
    chk("addr ptr", 32'(bif.ptr), 32'd1);
    drv(1, 1, 5, 4'hB, 0); #1;
    chk("addr stall", 32'(bif.in_ready), 32'd0);
    tick();
    chk("addr hold o5", 32'(bif.o5), 32'hA);
    drv(1, 1, 5, 4'h3, 8'h20); #1;
    chk("refill ready", 32'(bif.in_ready), 32'd1);
    tick();
    chk("refill o5", 32'(bif.o5), 32'h3);
    chk("refill o_valid", 32'(bif.o_valid), 32'h20);
    chk("refill fill", 32'(bif.fill_count), 32'd1);

    // Spurious acks with o_valid = 05
    drv(1, 1, 0, 4'h1, 8'h20); tick();
    drv(1, 1, 2, 4'h2, 0); tick();
    chk("mix o_valid", 32'(bif.o_valid), 32'h05);
    drv(0, 0, 0, 0, 8'hFF); tick();
    chk("spur o_valid", 32'(bif.o_valid), 32'h0);
    chk("spur fill", 32'(bif.fill_count), 32'd0);
    chk("spur o2", 32'(bif.o2), 32'h2);
    chk("spur o5", 32'(bif.o5), 32'h3);

    // Reset mid-stream
    drv(1, 1, 1, 4'h7, 0); tick();
    drv(1, 0, 0, 4'hF, 8'h02); rst = 1'b1; tick();
    rst = 1'b0; drv(0, 0, 0, 0, 0);
    chk("mrst o_valid", 32'(bif.o_valid), 32'h0);
    chk("mrst ptr", 32'(bif.ptr), 32'd0);
    chk("mrst o1", 32'(bif.o1), 32'h0);
    chk("mrst o0", 32'(bif.o0), 32'h0);

    // Randomized traffic, acks sparse enough to reach full/stall regularly
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 199) == 0);
      drv(1'($urandom_range(0, 3) != 0), 1'($urandom), 3'($urandom), 4'($urandom),
          ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00);
      tick();
    end
    rst = 1'b0; drv(0, 0, 0, 0, 0);
    repeat (2) tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
